// File: rtl/seg7_display_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | seg7_display_ctrl: N-digit hex 7-segment controller, parallel and scan |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module seg7_display_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int BLINK_DIV  = 25_000_000,
  parameter int SCAN_DIV   = 50_000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                      iCLK,
  input  logic                      iRST_N,
  input  logic [4*NUM_DIGITS-1:0]   iDIG,
  input  logic [NUM_DIGITS-1:0]     iDP,
  input  logic [NUM_DIGITS-1:0]     iBLINK_EN,
  input  logic                      iLZ_BLANK,
  input  logic                      iLOAD,
  output logic                      oACK,
  output logic [7*NUM_DIGITS-1:0]   oSEG,
  output logic [NUM_DIGITS-1:0]     oDP,
  output logic [6:0]                oSCAN_SEG,
  output logic                      oSCAN_DP,
  output logic [NUM_DIGITS-1:0]     oSCAN_SEL
);

  localparam int         c_BW     = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int         c_SW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int         c_IW     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [6:0] c_INV    = (ACTIVE_LOW != 0) ? 7'h00 : 7'h7F;
  localparam logic       c_DP_INV = (ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
  localparam logic [6:0] c_OFF    = 7'h7F ^ c_INV;
  localparam logic       c_DP_OFF = 1'b1 ^ c_DP_INV;

  // Decode table is written in lit-low form; polarity is applied afterwards.
  function automatic logic [6:0] f_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;  4'h1: seg = 7'h79;  4'h2: seg = 7'h24;  4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;  4'h5: seg = 7'h12;  4'h6: seg = 7'h02;  4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;  4'h9: seg = 7'h10;  4'hA: seg = 7'h08;  4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;  4'hD: seg = 7'h21;  4'hE: seg = 7'h06;  default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  logic [4*NUM_DIGITS-1:0] r_dig;
  logic [NUM_DIGITS-1:0]   r_dp;
  logic [NUM_DIGITS-1:0]   r_blink_en;
  logic                    r_lz;
  logic                    r_ack;
  logic [c_BW-1:0]         r_blink_cnt;
  logic                    r_phase;
  logic [c_SW-1:0]         r_scan_cnt;
  logic [c_IW-1:0]         r_scan_idx;
  logic [7*NUM_DIGITS-1:0] r_seg;
  logic [NUM_DIGITS-1:0]   r_dpo;
  logic [6:0]              r_scan_seg;
  logic                    r_scan_dp;
  logic [NUM_DIGITS-1:0]   r_scan_sel;

  logic [7*NUM_DIGITS-1:0] w_seg;
  logic [NUM_DIGITS-1:0]   w_dpo;
  logic                    w_seen;
  logic [3:0]              w_nib;
  logic                    w_lzb;
  logic                    w_off;
  logic                    w_blink_wrap;
  logic                    w_scan_wrap;
  logic [c_IW-1:0]         w_idx_nxt;
  logic [NUM_DIGITS-1:0]   w_sel_nxt;

  // Walk from the most significant digit so blanking stops at the first non-zero nibble.
  always_comb begin
    w_seg  = '0;
    w_dpo  = '0;
    w_seen = 1'b0;
    w_nib  = 4'd0;
    w_lzb  = 1'b0;
    w_off  = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      w_nib = r_dig[4*k +: 4];
      w_lzb = r_lz && !w_seen && (w_nib == 4'd0) && (k != 0);
      if (w_nib != 4'd0) w_seen = 1'b1;
      w_off = r_phase && r_blink_en[k];
      w_seg[7*k +: 7] = ((w_off || w_lzb) ? 7'h7F : f_decode(w_nib)) ^ c_INV;
      w_dpo[k]        = (w_off ? 1'b1 : ~r_dp[k]) ^ c_DP_INV;
    end
  end

  always_comb begin
    w_blink_wrap = (r_blink_cnt == c_BW'(BLINK_DIV - 1));
    w_scan_wrap  = (r_scan_cnt == c_SW'(SCAN_DIV - 1));
    w_idx_nxt    = r_scan_idx;
    if (w_scan_wrap)
      w_idx_nxt = (r_scan_idx == c_IW'(NUM_DIGITS - 1)) ? '0 : r_scan_idx + 1'b1;
    w_sel_nxt            = '0;
    w_sel_nxt[w_idx_nxt] = 1'b1;
  end

  // Scan port samples the registered parallel outputs, so it trails oSEG by one clock.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_dig       <= '0;
      r_dp        <= '0;
      r_blink_en  <= '0;
      r_lz        <= 1'b0;
      r_ack       <= 1'b0;
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
      r_scan_cnt  <= '0;
      r_scan_idx  <= '0;
      r_seg       <= {NUM_DIGITS{c_OFF}};
      r_dpo       <= {NUM_DIGITS{c_DP_OFF}};
      r_scan_seg  <= c_OFF;
      r_scan_dp   <= c_DP_OFF;
      r_scan_sel  <= NUM_DIGITS'(1);
    end else begin
      if (iLOAD) begin
        r_dig      <= iDIG;
        r_dp       <= iDP;
        r_blink_en <= iBLINK_EN;
        r_lz       <= iLZ_BLANK;
      end
      r_ack <= iLOAD;
      if (w_blink_wrap) begin
        r_blink_cnt <= '0;
        r_phase     <= ~r_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
      r_scan_cnt <= w_scan_wrap ? '0 : r_scan_cnt + 1'b1;
      r_scan_idx <= w_idx_nxt;
      r_seg      <= w_seg;
      r_dpo      <= w_dpo;
      r_scan_sel <= w_sel_nxt;
      r_scan_seg <= r_seg[7*w_idx_nxt +: 7];
      r_scan_dp  <= r_dpo[w_idx_nxt];
    end
  end

  assign oACK      = r_ack;
  assign oSEG      = r_seg;
  assign oDP       = r_dpo;
  assign oSCAN_SEG = r_scan_seg;
  assign oSCAN_DP  = r_scan_dp;
  assign oSCAN_SEL = r_scan_sel;

endmodule
`default_nettype wire
